trig_rom_arbiter: RTL and testbench

Shares one cos/sin lookup ROM pair among NUM_REQ requesters, for example the player and opponent motion updates in the kart game logic. Each requester presents an angle in degrees. The block grants one request per cycle using round-robin priority and drives the shared ROM address. When the ROM data comes back, it returns the cos/sin pair to the originating requester with a one-hot valid. This removes the duplicated cos/sin ROM instances per kart and scales to extra karts or projectiles.

---
 rtl/trig_rom_arbiter.sv | 113 +++++++++++
 tb/tb_trig_rom_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_rom_arbiter.sv
// Round-robin arbiter sharing one cos/sin ROM pair among NUM_REQ angle requesters.
// Latency: accept in cycle N, rom_addr in N+1, resp_valid/resp_cos/resp_sin in N+1+ROM_LATENCY.
// Backpressure: one grant per cycle via req_ready; no response backpressure, so consumers capture on resp_valid.
module trig_rom_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ANGLE_WIDTH = 9,
    parameter int TRIG_WIDTH  = 11,
    parameter int ROM_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ANGLE_WIDTH-1:0]         rom_addr,
    input  logic [TRIG_WIDTH-1:0]          rom_cos,
    input  logic [TRIG_WIDTH-1:0]          rom_sin,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [TRIG_WIDTH-1:0]          resp_cos,
    output logic [TRIG_WIDTH-1:0]          resp_sin,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DEPTH = 1 + ROM_LATENCY;
    localparam logic [ANGLE_WIDTH-1:0] DEG_360 = ANGLE_WIDTH'(360);

    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [ANGLE_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]     tag_q [DEPTH];
    logic [NUM_REQ-1:0]     tag_d [DEPTH];

    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [PTR_W-1:0]       search_idx;
    logic [ANGLE_WIDTH-1:0] grant_angle;
    logic [ANGLE_WIDTH-1:0] reduced_angle;
    logic                   accept;
    logic                   busy_c;

    // Round-robin search: first valid requester starting just after the last one granted.
    always_comb begin
        grant      = '0;
        grant_idx  = ptr_q;
        grant_any  = 1'b0;
        search_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            search_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[search_idx]) begin
                grant_any         = 1'b1;
                grant[search_idx] = 1'b1;
                grant_idx         = search_idx;
            end
        end
    end

    // Pick the granted angle and fold 360..511 back into 0..151.
    always_comb begin
        grant_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_angle = req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
            end
        end
        reduced_angle = (grant_angle >= DEG_360) ? (grant_angle - DEG_360) : grant_angle;
    end

    assign accept    = grant_any && !rst;
    assign req_ready = rst ? '0 : grant;

    // Next-state: pointer and address move only on acceptance; tags shift every cycle.
    always_comb begin
        ptr_d      = accept ? grant_idx : ptr_q;
        rom_addr_d = accept ? reduced_angle : rom_addr_q;
        tag_d[0]   = accept ? grant : '0;
        for (int s = 1; s < DEPTH; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // State registers; reset drops all in-flight tags and restores requester 0 priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            rom_addr_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Busy while any tag is still travelling alongside the ROM access.
    always_comb begin
        busy_c = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            busy_c = busy_c | (|tag_q[s]);
        end
    end

    assign rom_addr   = rom_addr_q;
    assign resp_valid = tag_q[DEPTH-1];
    assign resp_cos   = rom_cos;
    assign resp_sin   = rom_sin;
    assign busy       = busy_c;

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Directed bench for trig_rom_arbiter: a driver applies hand-computed vectors and queues
// the expected ROM address and response; an independent monitor checks them when due.
module tb_trig_rom_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 9;
    localparam int TW  = 11;
    localparam int LAT = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_angle;
    logic [NR-1:0]     req_ready;
    logic [AW-1:0]     rom_addr;
    logic [TW-1:0]     rom_cos;
    logic [TW-1:0]     rom_sin;
    logic [NR-1:0]     resp_valid;
    logic [TW-1:0]     resp_cos;
    logic [TW-1:0]     resp_sin;
    logic              busy;

    trig_rom_arbiter #(
        .NUM_REQ(NR), .ANGLE_WIDTH(AW), .TRIG_WIDTH(TW), .ROM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rom_addr(rom_addr), .rom_cos(rom_cos), .rom_sin(rom_sin),
        .resp_valid(resp_valid), .resp_cos(resp_cos), .resp_sin(resp_sin),
        .busy(busy)
    );

    typedef struct {
        int            due;
        logic [NR-1:0] vld;
        logic [TW-1:0] cos;
        logic [TW-1:0] sin;
    } resp_t;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } addr_t;

    resp_t rq[$];
    addr_t aq[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    mon_en = 0;

    function automatic logic [TW-1:0] cos_of(input logic [AW-1:0] a);
        return TW'((int'(a) * 3 + 17) % 2048);
    endfunction

    function automatic logic [TW-1:0] sin_of(input logic [AW-1:0] a);
        return TW'(1500 - int'(a));
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle ROM model: data for rom_addr appears ROM_LATENCY cycles later.
    logic [AW-1:0] rom_a1;
    always @(posedge clk) begin
        rom_a1  <= rom_addr;
        rom_cos <= cos_of(rom_a1);
        rom_sin <= sin_of(rom_a1);
    end

    // Monitor: runs at the falling edge, ahead of the driver in the same timestep.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic busy_exp;
                busy_exp = (rq.size() > 0) && (rq[0].due - LAT <= cyc);
                n_vec++;
                if (busy !== busy_exp) begin
                    n_err++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
                end
                if (aq.size() > 0 && aq[0].due == cyc) begin
                    n_vec++;
                    if (rom_addr !== aq[0].addr) begin
                        n_err++;
                        $display("FAIL rom_addr cyc=%0d got=%0d exp=%0d", cyc, rom_addr, aq[0].addr);
                    end
                    void'(aq.pop_front());
                end
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    n_vec++;
                    if (resp_valid !== rq[0].vld || resp_cos !== rq[0].cos || resp_sin !== rq[0].sin) begin
                        n_err++;
                        $display("FAIL resp cyc=%0d got vld=%b cos=%0d sin=%0d exp vld=%b cos=%0d sin=%0d",
                                 cyc, resp_valid, resp_cos, resp_sin, rq[0].vld, rq[0].cos, rq[0].sin);
                    end
                    void'(rq.pop_front());
                end else if (resp_valid !== '0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_resp cyc=%0d got vld=%b exp=00", cyc, resp_valid);
                end
            end
        end
    end

    // Apply one cycle of stimulus, check the grant, and queue what the accepted request must produce.
    task automatic step(input logic r, input logic [1:0] v, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [1:0] exp_rdy,
                        input logic [AW-1:0] exp_addr);
        resp_t re;
        addr_t ae;
        @(negedge clk);
        #2;
        rst       = r;
        req_valid = v;
        req_angle = {a1, a0};
        #1;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        if (r) begin
            rq.delete();
            aq.delete();
        end else if (exp_rdy != 2'b00) begin
            ae.due  = cyc + 1;
            ae.addr = exp_addr;
            aq.push_back(ae);
            re.due  = cyc + 1 + LAT;
            re.vld  = exp_rdy;
            re.cos  = cos_of(exp_addr);
            re.sin  = sin_of(exp_addr);
            rq.push_back(re);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 9'd0, 9'd0, 2'b00, 9'd0);
    endtask

    // Post-reset register state check.
    task automatic check_reset_state(input string tag);
        @(negedge clk);
        n_vec++;
        if (rom_addr !== '0 || resp_valid !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s got addr=%0d vld=%b busy=%b exp addr=0 vld=00 busy=0",
                     tag, rom_addr, resp_valid, busy);
        end
        mon_en = 1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_angle = '0;

        // Reset holds req_ready low even with requests pending.
        step(1'b1, 2'b11, 9'd5, 9'd6, 2'b00, 9'd0);
        step(1'b1, 2'b11, 9'd5, 9'd6, 2'b00, 9'd0);
        step(1'b1, 2'b11, 9'd5, 9'd6, 2'b00, 9'd0);
        check_reset_state("reset_state");

        // Contention: requester 0 first, then alternation.
        step(1'b0, 2'b11, 9'd100, 9'd200, 2'b01, 9'd100);
        step(1'b0, 2'b11, 9'd100, 9'd200, 2'b10, 9'd200);
        step(1'b0, 2'b11, 9'd101, 9'd201, 2'b01, 9'd101);
        step(1'b0, 2'b11, 9'd101, 9'd201, 2'b10, 9'd201);
        step(1'b0, 2'b11, 9'd102, 9'd202, 2'b01, 9'd102);
        step(1'b0, 2'b11, 9'd102, 9'd202, 2'b10, 9'd202);
        idle(4);

        // Single request on requester 0.
        step(1'b0, 2'b01, 9'd90, 9'd0, 2'b01, 9'd90);
        idle(4);

        // Angle wrap on requester 1.
        step(1'b0, 2'b10, 9'd0, 9'd359, 2'b10, 9'd359);
        step(1'b0, 2'b10, 9'd0, 9'd360, 2'b10, 9'd0);
        step(1'b0, 2'b10, 9'd0, 9'd450, 2'b10, 9'd90);
        step(1'b0, 2'b10, 9'd0, 9'd511, 2'b10, 9'd151);
        idle(4);

        // Back-to-back on requester 1 alone.
        step(1'b0, 2'b10, 9'd0, 9'd10, 2'b10, 9'd10);
        step(1'b0, 2'b10, 9'd0, 9'd20, 2'b10, 9'd20);
        step(1'b0, 2'b10, 9'd0, 9'd30, 2'b10, 9'd30);
        idle(4);

        // Withdrawal: requester 0 loses to 1, drops out, and is never answered.
        step(1'b0, 2'b01, 9'd5, 9'd0, 2'b01, 9'd5);
        step(1'b0, 2'b11, 9'd6, 9'd40, 2'b10, 9'd40);
        step(1'b0, 2'b10, 9'd6, 9'd41, 2'b10, 9'd41);
        idle(1);
        step(1'b0, 2'b11, 9'd7, 9'd8, 2'b01, 9'd7);
        idle(4);

        // Reset with a request in flight: its response must never appear.
        step(1'b0, 2'b01, 9'd270, 9'd0, 2'b01, 9'd270);
        step(1'b1, 2'b11, 9'd1, 9'd2, 2'b00, 9'd0);
        step(1'b1, 2'b00, 9'd0, 9'd0, 2'b00, 9'd0);
        check_reset_state("midflight_reset_state");
        idle(4);
        step(1'b0, 2'b11, 9'd33, 9'd44, 2'b01, 9'd33);
        idle(5);

        repeat (3) @(negedge clk);
        n_vec++;
        if (rq.size() != 0 || aq.size() != 0) begin
            n_err++;
            $display("FAIL drain got pending resp=%0d addr=%0d exp 0", rq.size(), aq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
